// File: rtl/dmem_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_lsu_ctrl
//
// Load/store sequencer between the execute stage and a word-only data RAM
// (combinational read, write on posedge while mem_we is high). Handles the
// RV32I loads and stores LB/LH/LW/LBU/LHU/SB/SH/SW. One request is in flight
// at a time, and the core stalls while req_ready is low.
//
// The RAM has no byte enables. Sub-word stores therefore read the target word
// first, replace the addressed lane, and then write the whole word back.
// Loads are lane-extracted and sign/zero-extended inside the controller.
//
// Build option:
//   DMEM_MISALIGN_ERR_EN
//     Defined   : a misaligned half/word request is answered with
//                 resp_err=1 and resp_rdata=0, and the RAM is not touched.
//     Undefined : a misaligned half/word address is aligned down and the
//                 request runs normally with resp_err=0.
//   size=2'b11 is rejected as an error in both builds.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   req_valid      core presents a request
//   req_ready      controller can accept (high only in IDLE)
//   req_write      1 = store, 0 = load
//   req_size       00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned   zero-extend a sub-word load
//   req_addr       byte address
//   req_wdata      store data (low bits used by sub-word stores)
//   resp_valid     one-cycle pulse when a request finishes
//   resp_rdata     extended load data; 0 for stores and errors
//   resp_err       misaligned or illegal size (qualified by resp_valid)
//   mem_addr       word-aligned RAM address (bits [1:0] always 0)
//   mem_wdata      full word written to the RAM
//   mem_we         RAM write enable (forced low while rst is high)
//   mem_re         RAM read strobe (informational)
//   mem_rdata      RAM combinational read data
//
// Latency from the accept edge to the resp_valid cycle:
//   error 1, load and SW 2, SB and SH 3.
// -----------------------------------------------------------------------------
module dmem_lsu_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32   // fixed at 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    MERGE_WR = 2'd2,
    RESP     = 2'd3
  } state_t;

  state_t              state_reg;

  // Request fields latched at the accept edge.
  logic                write_reg;
  logic [1:0]          size_reg;
  logic                unsigned_reg;
  logic [1:0]          addr_lo_reg;     // byte offset inside the word (after alignment)
  logic [DATA_W-1:0]   wdata_reg;

  // Registered outputs.
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [DATA_W-1:0]   mem_wdata_reg;   // also serves as the merge register
  logic                mem_we_reg;
  logic                mem_re_reg;
  logic                resp_valid_reg;
  logic                resp_err_reg;
  logic [DATA_W-1:0]   resp_rdata_reg;

  // ---------------------------------------------------------------------------
  // Request classification (evaluated on the incoming request in IDLE)
  // ---------------------------------------------------------------------------
  logic              req_err;
  logic [ADDR_W-1:0] req_addr_eff;

`ifdef DMEM_MISALIGN_ERR_EN
  logic req_misaligned;
  assign req_misaligned = ((req_size == SIZE_HALF) && req_addr[0]) ||
                          ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
  assign req_err        = (req_size == SIZE_ILL) || req_misaligned;
`else
  assign req_err        = (req_size == SIZE_ILL);
`endif

  // Align down to the access size. In the error-reporting build a misaligned
  // request never reaches the RAM, so this masking only matters when it is off.
  always_comb begin
    req_addr_eff = req_addr;
    if (req_size == SIZE_HALF) begin
      req_addr_eff[0] = 1'b0;
    end else if (req_size == SIZE_WORD) begin
      req_addr_eff[1:0] = 2'b00;
    end
  end

  // ---------------------------------------------------------------------------
  // Load extraction (little-endian lanes) from the word being read in ACCESS
  // ---------------------------------------------------------------------------
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_ext;

  always_comb begin
    ld_byte = mem_rdata[8*addr_lo_reg +: 8];
    ld_half = addr_lo_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_reg)
      SIZE_BYTE: ld_ext = {{24{ld_byte[7] & ~unsigned_reg}}, ld_byte};
      SIZE_HALF: ld_ext = {{16{ld_half[15] & ~unsigned_reg}}, ld_half};
      default:   ld_ext = mem_rdata;   // word loads ignore req_unsigned
    endcase
  end

  // ---------------------------------------------------------------------------
  // Store merge: per byte lane, take either the old RAM byte or the new data.
  // A byte store always sources wdata[7:0]; a half store sources the matching
  // byte of wdata[15:0] for the low/high byte of the selected half.
  // ---------------------------------------------------------------------------
  logic [3:0]        lane_sel;
  logic [DATA_W-1:0] merged_word;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    logic [7:0] new_byte;

    assign lane_sel[gi] = (size_reg == SIZE_BYTE) ? (addr_lo_reg == LANE)
                                                  : (addr_lo_reg[1] == LANE[1]);
    assign new_byte = (size_reg == SIZE_BYTE) ? wdata_reg[7:0]
                                              : wdata_reg[8*(gi%2) +: 8];
    assign merged_word[8*gi +: 8] = lane_sel[gi] ? new_byte : mem_rdata[8*gi +: 8];
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      write_reg      <= 1'b0;
      size_reg       <= 2'b00;
      unsigned_reg   <= 1'b0;
      addr_lo_reg    <= 2'b00;
      wdata_reg      <= '0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      mem_we_reg     <= 1'b0;
      mem_re_reg     <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            write_reg    <= req_write;
            size_reg     <= req_size;
            unsigned_reg <= req_unsigned;
            addr_lo_reg  <= req_addr_eff[1:0];
            wdata_reg    <= req_wdata;
            if (req_err) begin
              // Rejected requests skip the RAM entirely.
              resp_valid_reg <= 1'b1;
              resp_err_reg   <= 1'b1;
              resp_rdata_reg <= '0;
              state_reg      <= RESP;
            end else begin
              mem_addr_reg  <= {req_addr_eff[ADDR_W-1:2], 2'b00};
              mem_wdata_reg <= req_wdata;
              // A word store writes directly; everything else reads first.
              mem_we_reg    <= req_write && (req_size == SIZE_WORD);
              mem_re_reg    <= !(req_write && (req_size == SIZE_WORD));
              state_reg     <= ACCESS;
            end
          end
        end

        ACCESS: begin
          mem_we_reg <= 1'b0;
          mem_re_reg <= 1'b0;
          if (!write_reg) begin
            resp_rdata_reg <= ld_ext;
            resp_err_reg   <= 1'b0;
            resp_valid_reg <= 1'b1;
            state_reg      <= RESP;
          end else if (size_reg == SIZE_WORD) begin
            resp_rdata_reg <= '0;
            resp_err_reg   <= 1'b0;
            resp_valid_reg <= 1'b1;
            state_reg      <= RESP;
          end else begin
            // Read half of the read-modify-write: capture the merged word.
            mem_wdata_reg <= merged_word;
            mem_we_reg    <= 1'b1;
            state_reg     <= MERGE_WR;
          end
        end

        MERGE_WR: begin
          mem_we_reg     <= 1'b0;
          resp_rdata_reg <= '0;
          resp_err_reg   <= 1'b0;
          resp_valid_reg <= 1'b1;
          state_reg      <= RESP;
        end

        RESP: begin
          resp_valid_reg <= 1'b0;
          state_reg      <= IDLE;
        end

        default: begin
          mem_we_reg     <= 1'b0;
          mem_re_reg     <= 1'b0;
          resp_valid_reg <= 1'b0;
          state_reg      <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (state_reg == IDLE);
  assign resp_valid = resp_valid_reg;
  assign resp_err   = resp_err_reg;
  assign resp_rdata = resp_rdata_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  // A reset arriving mid-write must not let the pending write land.
  assign mem_we     = mem_we_reg & ~rst;
  assign mem_re     = mem_re_reg;

endmodule

// File: doc/dmem_lsu_ctrl.md
Name: dmem_lsu_ctrl

Overview:
Load/store sequencer between the execute stage and the word-only data memory (256 x 32 RAM, combinational read, write at posedge when write-enable is high).
- Handles RV32I LB/LH/LW/LBU/LHU/SB/SH/SW.
- Sub-word stores are done as read-modify-write, because the RAM has no byte enables.
- Loads are extracted and sign/zero-extended; misaligned accesses are flagged.
- One request is in flight at a time; the core stalls on req_ready.

Parameters:
ADDR_W, 32, width of the byte address on the core and memory sides
DATA_W, 32, data width; fixed at 32, other values unsupported

Ports:
Reset and clocking (already decided): reset rst, synchronous, active-high; clock clk.
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  core presents a request
req_ready  out  1  controller can accept; high only in IDLE
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal (funct3[1:0])
req_unsigned  in  1  zero-extend load (funct3[2])
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data; low bits used for sub-word stores
resp_valid  out  1  one-cycle pulse; request finished
resp_rdata  out  DATA_W  extended load data; 0 for stores and errors
resp_err  out  1  qualified by resp_valid; misaligned or illegal size
mem_addr  out  ADDR_W  word-aligned address to the RAM; bits [1:0] always 0
mem_wdata  out  DATA_W  full word to write
mem_we  out  1  RAM write enable
mem_re  out  1  RAM read strobe (informational)
mem_rdata  in  DATA_W  RAM combinational read data

Behaviour:
- Reset:
  - State IDLE; resp_valid, resp_err, resp_rdata, mem_we and mem_re all 0; req_ready 1 after reset.
  - mem_we is gated by !rst, so no write occurs during a reset cycle.
  - Reset in any state aborts the operation, with no RAM write and no response.
- Accept: at a posedge with req_valid && req_ready, latch write, size, unsigned, addr and wdata. req_ready is 0 in every other state.
- States: IDLE, ACCESS, MERGE_WR, RESP.
- IDLE -> ACCESS on accept. IDLE -> RESP with err=1 if the request is misaligned or illegal; no memory access happens.
- ACCESS: mem_addr = {addr[ADDR_W-1:2], 2'b00}.
  - Load: mem_re=1; at the edge, register the extended data into resp_rdata; go to RESP.
  - Word store: mem_we=1, mem_wdata=wdata; go to RESP.
  - Sub-word store: mem_re=1; at the edge, capture mem_rdata into the merge register; go to MERGE_WR.
- MERGE_WR: mem_we=1, mem_wdata = captured word with the target lane replaced.
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Data comes from wdata[7:0] or wdata[15:0]. Go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata and resp_err hold until the next response; they are only meaningful with resp_valid.
- Latency, counted from the accept edge to the resp_valid cycle:
  - Loads and SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Errors: 1 cycle.
- Load extraction (little-endian):
  - Byte = word[8*addr[1:0] +: 8].
  - Half = word[16*addr[1] +: 16].
  - Sign-extend unless req_unsigned. Word loads ignore req_unsigned.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. size=11 is always an error.
- req_* inputs are ignored outside the accept edge; changes mid-operation have no effect.

Optional Feature:
Macro DMEM_MISALIGN_ERR_EN.
- Defined: misaligned half/word requests respond with resp_err=1, resp_rdata=0 and no RAM access.
- Undefined: misaligned half/word requests are silently aligned down (half: addr[0] treated as 0; word: addr[1:0] treated as 0) and execute normally with resp_err=0.
- size=11 is an error in both builds.

Test Plan:
- Reset: hold rst for 2 cycles mid-MERGE_WR of an SB -> RAM word unchanged, resp_valid=0; afterwards req_ready=1 and all outputs 0.
- SW 0x11223344 to 0x40, then LW 0x40 -> resp_rdata=0x11223344, resp_err=0, resp_valid 2 cycles after accept.
- SB data 0xAB to 0x41 with RAM word 0x11223344 -> RAM becomes 0x1122AB44; resp_valid 3 cycles after accept.
- SH data 0xBEEF to 0x42 -> 0xBEEFAB44. LB 0x43 -> 0xFFFFFFBE. LBU 0x43 -> 0x000000BE. LH 0x42 -> 0xFFFFBEEF. LHU 0x42 -> 0x0000BEEF.
- LW 0x42 with DMEM_MISALIGN_ERR_EN -> resp_err=1, rdata=0, mem_we/mem_re never high; without the macro -> rdata=0xBEEFAB44, err=0.
- size=11 at 0x40 -> resp_err=1 in both builds. Back-to-back requests with req_valid held high -> each accepted only when req_ready=1, with no lost or duplicated accesses.
